// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared defaults and scan FSM encoding for the softmax datapath
package softmax_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_IN     = 100;
  localparam int DEF_SEL_WIDTH  = 7;

  // Select value 0 makes the input multiplexer return zero.
  localparam int SEL_NONE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/softmax_max_cmp.sv
// rtl/softmax_max_cmp.sv - signed strictly-greater compare and next running max/index select
module softmax_max_cmp
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SEL_WIDTH  = DEF_SEL_WIDTH
) (
  input  logic                         first,
  input  logic signed [DATA_WIDTH-1:0] cur_max,
  input  logic        [SEL_WIDTH-1:0]  cur_idx,
  input  logic signed [DATA_WIDTH-1:0] data,
  input  logic        [SEL_WIDTH-1:0]  idx,
  output logic signed [DATA_WIDTH-1:0] nxt_max,
  output logic        [SEL_WIDTH-1:0]  nxt_idx
);

  logic take;

  // Strictly greater keeps the lowest index on ties.
  assign take    = first || (data > cur_max);
  assign nxt_max = take ? data : cur_max;
  assign nxt_idx = take ? idx  : cur_idx;

endmodule

// File: rtl/softmax_max_scan.sv
// rtl/softmax_max_scan.sv - steps the input mux select and tracks the signed maximum
module softmax_max_scan
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_IN     = DEF_NUM_IN,
  parameter int SEL_WIDTH  = DEF_SEL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [SEL_WIDTH-1:0]  mux_sel,
  input  logic [DATA_WIDTH-1:0] mux_data,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic [SEL_WIDTH-1:0]  max_idx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [SEL_WIDTH-1:0] LAST_SEL  = SEL_WIDTH'(NUM_IN);
  localparam logic [SEL_WIDTH-1:0] FIRST_SEL = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] NO_SEL    = SEL_WIDTH'(SEL_NONE);

  scan_state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] run_max, cmp_max;
  logic        [SEL_WIDTH-1:0]  run_idx, cmp_idx;
  logic                         at_last;

  assign at_last = (mux_sel == LAST_SEL);
  assign busy    = (state == SCAN);
  assign done    = (state == DONE);

  softmax_max_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_cmp (
    .first   (mux_sel == FIRST_SEL),
    .cur_max (run_max),
    .cur_idx (run_idx),
    .data    (mux_data),
    .idx     (mux_sel),
    .nxt_max (cmp_max),
    .nxt_idx (cmp_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        if (abort)        state_nxt = IDLE;
        else if (at_last) state_nxt = DONE;
      end
      DONE: begin
        if (abort)      state_nxt = IDLE;
        else if (start) state_nxt = SCAN;
        else            state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_sel <= NO_SEL;
      run_max <= '0;
      run_idx <= NO_SEL;
      max_val <= '0;
      max_idx <= NO_SEL;
    end else begin
      if (state_nxt == SCAN)
        mux_sel <= (state == SCAN) ? mux_sel + FIRST_SEL : FIRST_SEL;
      else
        mux_sel <= NO_SEL;

      if (state == SCAN && !abort) begin
        run_max <= cmp_max;
        run_idx <= cmp_idx;
      end

      // Published result includes the last element sampled on this edge.
      if (state == SCAN && state_nxt == DONE) begin
        max_val <= cmp_max;
        max_idx <= cmp_idx;
      end
    end
  end

endmodule
